// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the CPU memory stage: FSM states, RISC-V funct3
// codes, mcause trap codes and small request-decode helpers.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } mau_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] CAUSE_NONE            = 4'd0;
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_ACCESS      = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_STORE_ACCESS     = 4'd7;

  // Loads accept LB/LH/LW/LBU/LHU; stores accept SB/SH/SW only.
  function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
    logic ok;
    if (wr) begin
      ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end else begin
      ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
    end
    return ok;
  endfunction

  // Store data is right-justified; bytes above the access size are zeroed.
  function automatic logic [31:0] store_mask(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {24'h0, d[7:0]};
      2'b01:   r = {16'h0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational sign/zero extension of right-justified raw load data by funct3.
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] raw_i,
  output logic [31:0] data_o
);

  // Select extension by access width and signedness.
  always_comb begin
    data_o = raw_i;
    case (funct3_i)
      F3_LB:   data_o = {{24{raw_i[7]}}, raw_i[7:0]};
      F3_LBU:  data_o = {24'h0, raw_i[7:0]};
      F3_LH:   data_o = {{16{raw_i[15]}}, raw_i[15:0]};
      F3_LHU:  data_o = {16'h0, raw_i[15:0]};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU memory stage in front of load_store: one request at a time, one-cycle
// bus strobe, load data capture/extension, single-cycle trap-aware response.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic [3:0]        rsp_cause,
  output logic              ls_en,
  output logic              ls_wr,
  output logic [2:0]        ls_size,
  output logic [31:0]       ls_addr,
  output logic [31:0]       ls_wdata,
  input  logic [31:0]       ls_rdata,
  input  logic              ls_exception
);

  mau_state_e  state_q;
  logic        wr_q;
  logic        exc_q;
  logic        ls_en_q;
  logic        ls_wr_q;
  logic [2:0]  ls_size_q;
  logic [31:0] ls_addr_q;
  logic [31:0] ls_wdata_q;
  logic        rsp_valid_q;
  logic        rsp_fault_q;
  logic [3:0]  rsp_cause_q;
  logic [31:0] rsp_rdata_q;
  logic        misalign;
  logic [31:0] load_ext;

  // Misaligned halfword/word detection, keyed on the funct3 size field.
  always_comb begin
    misalign = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    case (req_funct3[1:0])
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = |req_addr[1:0];
      default: misalign = 1'b0;
    endcase
`endif
  end

  load_extend u_load_extend (
    .funct3_i (ls_size_q),
    .raw_i    (ls_rdata),
    .data_o   (load_ext)
  );

  // Request FSM; every output is registered so reset clears it asynchronously.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      exc_q       <= 1'b0;
      ls_en_q     <= 1'b0;
      ls_wr_q     <= 1'b0;
      ls_size_q   <= '0;
      ls_addr_q   <= '0;
      ls_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_cause_q <= CAUSE_NONE;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            wr_q <= req_wr;
            if (misalign) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= 1'b1;
              rsp_cause_q <= req_wr ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
              rsp_rdata_q <= '0;
            end else if (!f3_legal(req_wr, req_funct3)) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= 1'b1;
              rsp_cause_q <= req_wr ? CAUSE_STORE_ACCESS : CAUSE_LOAD_ACCESS;
              rsp_rdata_q <= '0;
            end else begin
              state_q    <= ST_ACCESS;
              ls_en_q    <= 1'b1;
              ls_wr_q    <= req_wr;
              ls_size_q  <= req_funct3;
              ls_addr_q  <= 32'(req_addr);
              ls_wdata_q <= req_wr ? store_mask(req_funct3, req_wdata) : '0;
            end
          end
        end
        ST_ACCESS: begin
          ls_en_q <= 1'b0;
          ls_wr_q <= 1'b0;
          if (wr_q) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= ls_exception;
            rsp_cause_q <= ls_exception ? CAUSE_STORE_ACCESS : CAUSE_NONE;
            rsp_rdata_q <= '0;
          end else begin
            state_q <= ST_WAIT;
            exc_q   <= ls_exception;
          end
        end
        ST_WAIT: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
          rsp_fault_q <= exc_q | ls_exception;
          rsp_cause_q <= (exc_q | ls_exception) ? CAUSE_LOAD_ACCESS : CAUSE_NONE;
          rsp_rdata_q <= (exc_q | ls_exception) ? '0 : load_ext;
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          exc_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
          rsp_fault_q <= 1'b0;
          rsp_cause_q <= CAUSE_NONE;
          rsp_rdata_q <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_cause = rsp_cause_q;
  assign ls_en     = ls_en_q;
  assign ls_wr     = ls_wr_q;
  assign ls_size   = ls_size_q;
  assign ls_addr   = ls_addr_q;
  assign ls_wdata  = ls_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit; expectations follow the
// MEM_ALIGN_CHECK_EN setting of the build.
module tb_mem_access_unit;

  logic        CLK;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [3:0]  rsp_cause;
  logic        ls_en;
  logic        ls_wr;
  logic [2:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_exception;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.ADDR_W(32)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_fault    (rsp_fault),
    .rsp_cause    (rsp_cause),
    .ls_en        (ls_en),
    .ls_wr        (ls_wr),
    .ls_size      (ls_size),
    .ls_addr      (ls_addr),
    .ls_wdata     (ls_wdata),
    .ls_rdata     (ls_rdata),
    .ls_exception (ls_exception)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge; returns 1 ns after the accepting edge.
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    @(negedge CLK);
    req_valid  = 1'b1;
    req_wr     = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_wr       = 1'b0;
    req_funct3   = '0;
    req_addr     = '0;
    req_wdata    = '0;
    ls_rdata     = '0;
    ls_exception = 1'b0;
    #12;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_ls_en", {31'h0, ls_en}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_ls_addr", ls_addr, 32'h0);
    chk("rst_rsp_cause", {28'h0, rsp_cause}, 32'h0);
    @(negedge CLK);
    reset = 1'b0;

    // LB, sign-extended; req_* changed after accept must be ignored
    ls_rdata = 32'h0000_0080;
    issue(1'b0, 3'b000, 32'h0100_0003, 32'h0);
    chk("lb_e0_en", {31'h0, ls_en}, 32'h1);
    chk("lb_e0_size", {29'h0, ls_size}, 32'h0);
    chk("lb_e0_addr", ls_addr, 32'h0100_0003);
    chk("lb_e0_wr", {31'h0, ls_wr}, 32'h0);
    chk("lb_e0_ready", {31'h0, req_ready}, 32'h0);
    req_valid = 1'b1;
    req_addr  = 32'h0555_5554;
    tick();
    req_valid = 1'b0;
    chk("lb_e1_en", {31'h0, ls_en}, 32'h0);
    chk("lb_e1_rsp", {31'h0, rsp_valid}, 32'h0);
    chk("lb_e1_addr_hold", ls_addr, 32'h0100_0003);
    tick();
    chk("lb_e2_rsp", {31'h0, rsp_valid}, 32'h1);
    chk("lb_e2_data", rsp_rdata, 32'hFFFF_FF80);
    chk("lb_e2_fault", {31'h0, rsp_fault}, 32'h0);
    tick();
    chk("lb_e3_rsp", {31'h0, rsp_valid}, 32'h0);
    chk("lb_e3_ready", {31'h0, req_ready}, 32'h1);

    // LHU, zero-extended
    ls_rdata = 32'h1234_F00D;
    issue(1'b0, 3'b101, 32'h0100_0002, 32'h0);
    tick();
    tick();
    chk("lhu_rsp", {31'h0, rsp_valid}, 32'h1);
    chk("lhu_data", rsp_rdata, 32'h0000_F00D);
    tick();

    // LH, sign-extended
    ls_rdata = 32'h0000_8001;
    issue(1'b0, 3'b001, 32'h0100_0000, 32'h0);
    tick();
    tick();
    chk("lh_data", rsp_rdata, 32'hFFFF_8001);
    tick();

    // LW pass-through
    ls_rdata = 32'hDEAD_BEEF;
    issue(1'b0, 3'b010, 32'h0100_0004, 32'h0);
    tick();
    tick();
    chk("lw_rsp", {31'h0, rsp_valid}, 32'h1);
    chk("lw_data", rsp_rdata, 32'hDEAD_BEEF);
    chk("lw_fault", {31'h0, rsp_fault}, 32'h0);
    tick();

    // SB with byte masking
    issue(1'b1, 3'b000, 32'h0200_0000, 32'hAABB_CC41);
    chk("sb_e0_en", {31'h0, ls_en}, 32'h1);
    chk("sb_e0_wr", {31'h0, ls_wr}, 32'h1);
    chk("sb_e0_wdata", ls_wdata, 32'h0000_0041);
    chk("sb_e0_addr", ls_addr, 32'h0200_0000);
    tick();
    chk("sb_e1_rsp", {31'h0, rsp_valid}, 32'h1);
    chk("sb_e1_fault", {31'h0, rsp_fault}, 32'h0);
    chk("sb_e1_data", rsp_rdata, 32'h0);
    chk("sb_e1_wr", {31'h0, ls_wr}, 32'h0);
    chk("sb_e1_en", {31'h0, ls_en}, 32'h0);
    tick();
    chk("sb_e2_rsp", {31'h0, rsp_valid}, 32'h0);
    chk("sb_e2_ready", {31'h0, req_ready}, 32'h1);

    // SH masks to the low halfword
    issue(1'b1, 3'b001, 32'h0200_0002, 32'hAABB_CC41);
    chk("sh_wdata", ls_wdata, 32'h0000_CC41);
    tick();
    tick();

    // Misaligned LW
    ls_rdata = 32'h0BAD_F00D;
    issue(1'b0, 3'b010, 32'h0100_0002, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_en", {31'h0, ls_en}, 32'h0);
    chk("mis_rsp", {31'h0, rsp_valid}, 32'h1);
    chk("mis_fault", {31'h0, rsp_fault}, 32'h1);
    chk("mis_cause", {28'h0, rsp_cause}, 32'h4);
    chk("mis_data", rsp_rdata, 32'h0);
    tick();
    chk("mis_e1_rsp", {31'h0, rsp_valid}, 32'h0);
`else
    chk("mis_en", {31'h0, ls_en}, 32'h1);
    chk("mis_addr", ls_addr, 32'h0100_0002);
    tick();
    tick();
    chk("mis_rsp", {31'h0, rsp_valid}, 32'h1);
    chk("mis_fault", {31'h0, rsp_fault}, 32'h0);
    chk("mis_data", rsp_rdata, 32'h0BAD_F00D);
    tick();
`endif

    // Load with bus exception raised during WAIT
    issue(1'b0, 3'b010, 32'h0100_0008, 32'h0);
    tick();
    ls_exception = 1'b1;
    tick();
    ls_exception = 1'b0;
    chk("lexc_rsp", {31'h0, rsp_valid}, 32'h1);
    chk("lexc_fault", {31'h0, rsp_fault}, 32'h1);
    chk("lexc_cause", {28'h0, rsp_cause}, 32'h5);
    chk("lexc_data", rsp_rdata, 32'h0);
    tick();

    // Store with illegal funct3: early fault, no bus cycle
    issue(1'b1, 3'b011, 32'h0200_0000, 32'h1234_5678);
    chk("sill_en", {31'h0, ls_en}, 32'h0);
    chk("sill_rsp", {31'h0, rsp_valid}, 32'h1);
    chk("sill_fault", {31'h0, rsp_fault}, 32'h1);
    chk("sill_cause", {28'h0, rsp_cause}, 32'h7);
    tick();
    chk("sill_e1_ready", {31'h0, req_ready}, 32'h1);

    // Load with illegal funct3
    issue(1'b0, 3'b110, 32'h0100_0000, 32'h0);
    chk("lill_en", {31'h0, ls_en}, 32'h0);
    chk("lill_cause", {28'h0, rsp_cause}, 32'h5);
    tick();

    // Reset during WAIT discards the request
    ls_rdata = 32'h5555_AAAA;
    issue(1'b0, 3'b010, 32'h0100_000C, 32'h0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("rw_en", {31'h0, ls_en}, 32'h0);
    chk("rw_rsp", {31'h0, rsp_valid}, 32'h0);
    chk("rw_ready", {31'h0, req_ready}, 32'h1);
    @(negedge CLK);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rw_no_rsp", {31'h0, rsp_valid}, 32'h0);
    end

    // Next LW completes normally
    ls_rdata = 32'hCAFE_0123;
    issue(1'b0, 3'b010, 32'h0100_0010, 32'h0);
    chk("post_en", {31'h0, ls_en}, 32'h1);
    tick();
    tick();
    chk("post_rsp", {31'h0, rsp_valid}, 32'h1);
    chk("post_data", rsp_rdata, 32'hCAFE_0123);
    chk("post_fault", {31'h0, rsp_fault}, 32'h0);
    tick();
    chk("post_ready", {31'h0, req_ready}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
